// File: rtl/w5300_bus_arbiter.sv
// w5300_bus_arbiter: round-robin arbiter sharing the W5300 register bus among NUM_REQ engines.
// Optional hold timeout enabled by defining W5300_ARB_TIMEOUT_EN.
module w5300_bus_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          IDX_W     = $clog2(NUM_REQ),
  parameter logic [10:0] IDLE_ADDR = 11'h7fe,
  parameter int          MAX_HOLD  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*11-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    req_op_state,
  output logic [10:0]           addr,
  output logic [15:0]           wr_data,
  input  logic                  op_state,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  timeout_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_REL   = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);
  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] elig;
  logic               tmo;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic [10:0]        addr_mux;
  logic [15:0]        wd_mux;
`ifdef W5300_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;
  logic               to_q, to_d;
  assign tmo         = (state_q == S_GRANT) && (hold_q == HW'(MAX_HOLD - 1));
  // a timed-out owner stays ineligible until it lets go of its request
  assign elig        = req & ~blk_q;
  assign timeout_err = to_q;
  always_comb begin
    hold_d = (state_q == S_GRANT) ? hold_q + 1'b1 : '0;
    blk_d  = (blk_q & req) | (tmo ? gnt_q : '0);
    to_d   = to_q | tmo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      blk_q  <= '0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      blk_q  <= blk_d;
      to_q   <= to_d;
    end
  end
`else
  assign tmo         = 1'b0;
  assign elig        = req;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end
  always_comb begin
    addr_mux = '0;
    wd_mux   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_mux = addr_mux | (gnt_q[i] ? req_addr[i*11+:11] : 11'd0);
      wd_mux   = wd_mux | (gnt_q[i] ? req_wr_data[i*16+:16] : 16'd0);
    end
  end
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    case (state_q)
      S_IDLE: if (found) begin
        state_d    = S_GRANT;
        gnt_d      = NUM_REQ'(1) << win;
        grant_id_d = win;
        ptr_d      = (win == LAST) ? '0 : win + 1'b1;
      end
      S_GRANT: if (!req[grant_id_q] || tmo) begin
        state_d = S_REL;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end
  assign gnt          = gnt_q;
  assign busy         = |gnt_q;
  assign grant_id     = grant_id_q;
  assign req_op_state = {NUM_REQ{op_state}} & gnt_q;
  assign addr         = busy ? addr_mux : IDLE_ADDR;
  assign wr_data      = busy ? wd_mux : 16'd0;
endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// tb_w5300_bus_arbiter: vector-table and sequence checks for w5300_bus_arbiter.
module tb_w5300_bus_arbiter;
  localparam logic [10:0] IDLE_A = 11'h7fe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [43:0] req_addr;
  logic [63:0] req_wr_data;
  logic [3:0]  gnt, req_op_state;
  logic [10:0] addr;
  logic [15:0] wr_data;
  logic        op_state = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  int          total = 0;
  int          passed = 0;
  always #5 clk = ~clk;
  w5300_bus_arbiter #(.NUM_REQ(4), .IDX_W(2), .IDLE_ADDR(IDLE_A), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .gnt(gnt), .req_op_state(req_op_state), .addr(addr), .wr_data(wr_data),
    .op_state(op_state), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );
  function automatic logic [10:0] a_of(int i);
    return 11'(11'h0a0 + i * 17);
  endfunction
  function automatic logic [15:0] d_of(int i);
    return 16'(16'hc000 + i * 16'h0111);
  endfunction
  function automatic logic [10:0] exp_addr(logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return a_of(i);
    return IDLE_A;
  endfunction
  function automatic logic [15:0] exp_wd(logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return d_of(i);
    return 16'd0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] ros, input logic [1:0] id);
    chk({tag, " gnt"}, 32'(gnt), 32'(g));
    chk({tag, " busy"}, 32'(busy), 32'(|g));
    chk({tag, " req_op_state"}, 32'(req_op_state), 32'(ros));
    chk({tag, " grant_id"}, 32'(grant_id), 32'(id));
    chk({tag, " addr"}, 32'(addr), 32'(exp_addr(g)));
    chk({tag, " wr_data"}, 32'(wr_data), 32'(exp_wd(g)));
  endtask
  typedef struct {
    logic [3:0] req;
    logic       op;
    logic [3:0] gnt;
    logic [3:0] ros;
    logic [1:0] id;
  } vec_t;
  vec_t vt[13];
  initial begin
    int cnt;
    logic [3:0] g;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*11+:11]    = a_of(i);
      req_wr_data[i*16+:16] = d_of(i);
    end
    vt[0]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 2'd2};
    vt[1]  = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 2'd2};
    vt[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd2};
    vt[3]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd2};
    vt[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd2};
    vt[5]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 2'd1};
    vt[6]  = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 2'd1};
    vt[7]  = '{4'b1010, 1'b0, 4'b0010, 4'b0000, 2'd1};
    vt[8]  = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 2'd1};
    vt[9]  = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 2'd1};
    vt[10] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 2'd3};
    vt[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd3};
    vt[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd3};
    step();
    step();
    chk_all("reset", 4'b0000, 4'b0000, 2'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      req      = vt[v].req;
      op_state = vt[v].op;
      step();
      chk_all($sformatf("vec%0d", v), vt[v].gnt, vt[v].ros, vt[v].id);
    end
    @(negedge clk);
    op_state = 1'b0;
    req      = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int e;
      e = n % 4;
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (gnt == 4'b0000 && cnt < 6);
      g = 4'b0001 << e;
      chk_all($sformatf("rr%0d", n), g, 4'b0000, 2'(e));
      repeat (4) step();
      chk($sformatf("rr%0d held", n), 32'(gnt), 32'(g));
      @(negedge clk);
      req[e] = 1'b0;
      step();
      chk($sformatf("rr%0d release addr", n), 32'(addr), 32'(IDLE_A));
      @(negedge clk);
      req[e] = 1'b1;
    end
    @(negedge clk);
    req = 4'b0000;
    repeat (3) step();
    @(negedge clk);
    req = 4'b0100;
    step();
    chk("pre-reset gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_all("mid reset", 4'b0000, 4'b0000, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("post-reset gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'b0000;
    repeat (3) step();
`ifdef W5300_ARB_TIMEOUT_EN
    @(negedge clk);
    req = 4'b0001;
    step();
    cnt = (gnt == 4'b0001) ? 1 : 0;
    @(negedge clk);
    req = 4'b0011;
    for (int c = 0; c < 40 && gnt == 4'b0001; c++) begin
      step();
      if (gnt == 4'b0001) cnt++;
    end
    chk("timeout hold cycles", 32'(cnt), 32'd16);
    chk("timeout_err set", 32'(timeout_err), 32'd1);
    step();
    step();
    chk("after timeout gnt", 32'(gnt), 32'h2);
    chk("timeout_err sticky", 32'(timeout_err), 32'd1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
